// File: rtl/brq_pkg.sv
// brq_pkg: shared LSU types and helpers for the brq core.
// Split-access states exist only when BRQ_LSU_MISALIGNED_EN is defined.
package brq_pkg;

    typedef enum logic [1:0] {
        LSU_WORD = 2'b00,
        LSU_HALF = 2'b01,
        LSU_BYTE = 2'b10
    } lsu_type_e;

`ifdef BRQ_LSU_MISALIGNED_EN
    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_REQ_A,
        LSU_WAIT_A,
        LSU_REQ_B,
        LSU_WAIT_B
    } lsu_state_e;
`else
    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_REQ_A,
        LSU_WAIT_A
    } lsu_state_e;
`endif

    function automatic logic lsu_split(lsu_type_e t, logic [1:0] off);
        return ((t == LSU_WORD) && (off != 2'b00)) ||
               ((t == LSU_HALF) && (off == 2'b11));
    endfunction

    function automatic logic [3:0] lsu_be_base(lsu_type_e t);
        case (t)
            LSU_HALF: return 4'b0011;
            LSU_BYTE: return 4'b0001;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/brq_lsu_resp_if.sv
// brq_lsu_resp_if: data-memory request/grant/rvalid bus.
// master = LSU side, slave = memory side.
interface brq_lsu_resp_if;

    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
    );

endinterface

// File: rtl/brq_lsu_rdata_align.sv
// brq_lsu_rdata_align: pick byte/half/word out of the (possibly
// two-word) load source at the given offset and extend it.
module brq_lsu_rdata_align
    import brq_pkg::*;
(
    input  logic [63:0] src_i,
    input  logic [1:0]  off_i,
    input  lsu_type_e   type_i,
    input  logic        sign_ext_i,
    output logic [31:0] data_o
);

    logic [31:0] low;

    assign low = 32'(src_i >> {off_i, 3'b000});

    always_comb begin
        data_o = low;
        case (type_i)
            LSU_HALF: data_o = {{16{sign_ext_i & low[15]}}, low[15:0]};
            LSU_BYTE: data_o = {{24{sign_ext_i & low[7]}}, low[7:0]};
            default:  data_o = low;
        endcase
    end

endmodule

// File: rtl/brq_lsu_resp.sv
// brq_lsu_resp: LSU bus sequencer and writeback response generator.
// BRQ_LSU_MISALIGNED_EN enables two-part misaligned accesses.
module brq_lsu_resp
    import brq_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           lsu_req_i,
    input  logic           lsu_we_i,
    input  logic [1:0]     lsu_type_i,
    input  logic           lsu_sign_ext_i,
    input  logic [31:0]    lsu_addr_i,
    input  logic [31:0]    lsu_wdata_i,
    output logic           busy_o,
    brq_lsu_resp_if.master bus,
    output logic [31:0]    rf_wdata_lsu_o,
    output logic           rf_we_lsu_o,
    output logic           lsu_resp_valid_o,
    output logic           lsu_resp_err_o
);

    lsu_state_e  state_q, state_d;
    lsu_type_e   type_q, type_d;
    logic        we_q, we_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done;
    logic        part_b;
    logic        comp_err;
    logic [63:0] src;
    logic [31:0] ld_data;
    logic [7:0]  be8;
    logic [4:0]  sh;

`ifdef BRQ_LSU_MISALIGNED_EN
    logic        split_q, split_d;
    logic [31:0] rdata_a_q, rdata_a_d;

    assign src = split_q ? {bus.data_rdata_i, rdata_a_q}
                         : {32'b0, bus.data_rdata_i};
    assign comp_err = 1'b0;
    assign busy_o = (state_q != LSU_IDLE);
`else
    logic mis_q, mis_d;

    assign src = {32'b0, bus.data_rdata_i};
    assign comp_err = mis_q;
    assign busy_o = (state_q != LSU_IDLE) | mis_q;
`endif

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        we_d    = we_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef BRQ_LSU_MISALIGNED_EN
        split_d   = split_q;
        rdata_a_d = rdata_a_q;
`else
        mis_d = 1'b0;
`endif
        done           = 1'b0;
        part_b         = 1'b0;
        bus.data_req_o = 1'b0;
        unique case (state_q)
            LSU_IDLE: begin
                if (lsu_req_i && !busy_o) begin
                    type_d  = lsu_type_e'(lsu_type_i);
                    we_d    = lsu_we_i;
                    sext_d  = lsu_sign_ext_i;
                    addr_d  = lsu_addr_i;
                    wdata_d = lsu_wdata_i;
`ifdef BRQ_LSU_MISALIGNED_EN
                    split_d = lsu_split(lsu_type_e'(lsu_type_i), lsu_addr_i[1:0]);
                    state_d = LSU_REQ_A;
`else
                    // Misaligned requests fail locally with no bus traffic
                    if (lsu_split(lsu_type_e'(lsu_type_i), lsu_addr_i[1:0]))
                        mis_d = 1'b1;
                    else
                        state_d = LSU_REQ_A;
`endif
                end
            end
            LSU_REQ_A: begin
                bus.data_req_o = 1'b1;
                if (bus.data_gnt_i) state_d = LSU_WAIT_A;
            end
            LSU_WAIT_A: begin
                if (bus.data_rvalid_i) begin
`ifdef BRQ_LSU_MISALIGNED_EN
                    if (split_q && !bus.data_err_i) begin
                        rdata_a_d = bus.data_rdata_i;
                        state_d   = LSU_REQ_B;
                    end else begin
                        done    = 1'b1;
                        state_d = LSU_IDLE;
                    end
`else
                    done    = 1'b1;
                    state_d = LSU_IDLE;
`endif
                end
            end
`ifdef BRQ_LSU_MISALIGNED_EN
            LSU_REQ_B: begin
                bus.data_req_o = 1'b1;
                part_b         = 1'b1;
                if (bus.data_gnt_i) state_d = LSU_WAIT_B;
            end
            LSU_WAIT_B: begin
                if (bus.data_rvalid_i) begin
                    done    = 1'b1;
                    state_d = LSU_IDLE;
                end
            end
`endif
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= LSU_IDLE;
            type_q  <= LSU_WORD;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
`ifdef BRQ_LSU_MISALIGNED_EN
            split_q   <= 1'b0;
            rdata_a_q <= 32'b0;
`else
            mis_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            we_q    <= we_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef BRQ_LSU_MISALIGNED_EN
            split_q   <= split_d;
            rdata_a_q <= rdata_a_d;
`else
            mis_q <= mis_d;
`endif
        end
    end

    // Upper nibble of be8 is the spill into the second word
    assign be8 = {4'b0000, lsu_be_base(type_q)} << addr_q[1:0];
    assign sh  = {addr_q[1:0], 3'b000};

    assign bus.data_addr_o  = bus.data_req_o
                            ? ({addr_q[31:2], 2'b00} + (part_b ? 32'd4 : 32'd0))
                            : 32'b0;
    assign bus.data_we_o    = bus.data_req_o & we_q;
    assign bus.data_be_o    = bus.data_req_o ? (part_b ? be8[7:4] : be8[3:0]) : 4'b0;
    assign bus.data_wdata_o = bus.data_req_o
                            ? ((wdata_q << sh) | (wdata_q >> (6'd32 - {1'b0, sh})))
                            : 32'b0;

    brq_lsu_rdata_align u_align (
        .src_i      (src),
        .off_i      (addr_q[1:0]),
        .type_i     (type_q),
        .sign_ext_i (sext_q),
        .data_o     (ld_data)
    );

    assign lsu_resp_valid_o = done | comp_err;
    assign lsu_resp_err_o   = (done & bus.data_err_i) | comp_err;
    assign rf_we_lsu_o      = done & ~we_q & ~bus.data_err_i;
    assign rf_wdata_lsu_o   = done ? ld_data : 32'b0;

    a_no_rvalid_in_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.data_rvalid_i && bus.data_req_o));

endmodule

// File: tb/tb_brq_lsu_resp.sv
// tb_brq_lsu_resp: randomized + directed accesses against a byte-level
// reference model; outputs compared every cycle on the falling edge.
module tb_brq_lsu_resp;

`ifdef BRQ_LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        lsu_req, lsu_we, lsu_sext;
    logic [1:0]  lsu_type;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        busy, rf_we, resp_valid, resp_err;
    logic [31:0] rf_wdata;

    brq_lsu_resp_if bus ();

    brq_lsu_resp dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .lsu_req_i        (lsu_req),
        .lsu_we_i         (lsu_we),
        .lsu_type_i       (lsu_type),
        .lsu_sign_ext_i   (lsu_sext),
        .lsu_addr_i       (lsu_addr),
        .lsu_wdata_i      (lsu_wdata),
        .busy_o           (busy),
        .bus              (bus),
        .rf_wdata_lsu_o   (rf_wdata),
        .rf_we_lsu_o      (rf_we),
        .lsu_resp_valid_o (resp_valid),
        .lsu_resp_err_o   (resp_err)
    );

    int checks = 0;
    int errors = 0;

    logic        exp_chk = 1'b0;
    logic        exp_busy, exp_req, exp_we, exp_valid, exp_err, exp_rfwe, exp_zero;
    logic [31:0] exp_addr, exp_wdata, exp_rfwdata;
    logic [3:0]  exp_be;
    logic        lit_bus_on, lit_res_on;
    logic [31:0] lit_addr, lit_wd, lit_res;
    logic [3:0]  lit_be;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_chk) begin
            chk("busy", busy, exp_busy);
            chk("data_req", bus.data_req_o, exp_req);
            if (exp_req) begin
                chk("data_addr", bus.data_addr_o, exp_addr);
                chk("data_be", bus.data_be_o, exp_be);
                chk("data_we", bus.data_we_o, exp_we);
                chk("data_wdata", bus.data_wdata_o, exp_wdata);
                if (lit_bus_on) begin
                    chk("lit_addr", bus.data_addr_o, lit_addr);
                    chk("lit_be", bus.data_be_o, lit_be);
                    chk("lit_wdata", bus.data_wdata_o, lit_wd);
                end
            end
            if (exp_zero) begin
                chk("zero_addr", bus.data_addr_o, 32'h0);
                chk("zero_be", bus.data_be_o, 32'h0);
                chk("zero_we", bus.data_we_o, 32'h0);
                chk("zero_wdata", bus.data_wdata_o, 32'h0);
                chk("zero_rf_wdata", rf_wdata, 32'h0);
            end
            chk("resp_valid", resp_valid, exp_valid);
            chk("resp_err", resp_err, exp_err);
            chk("rf_we", rf_we, exp_rfwe);
            if (exp_rfwe) begin
                chk("rf_wdata", rf_wdata, exp_rfwdata);
                if (lit_res_on) chk("lit_rf_wdata", rf_wdata, lit_res);
            end
        end
    end

    // Reference model: byte-lane view of an access
    function automatic int size_of(input logic [1:0] t);
        return (t == 2'b00) ? 4 : (t == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic [7:0] touched(input logic [1:0] t, input logic [1:0] off);
        logic [7:0] m = 8'h0;
        for (int i = 0; i < size_of(t); i++) m[int'(off) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] place(input logic [31:0] w, input logic [1:0] off);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*((i + int'(off)) % 4) +: 8] = w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] load_val(input logic [63:0] b, input logic [1:0] t,
                                             input logic sx, input logic [1:0] off);
        int sz = size_of(t);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = b[8*(int'(off) + i) +: 8];
        if (sx && sz < 4 && v[8*sz-1])
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_busy = 0; exp_req = 0; exp_we = 0; exp_valid = 0; exp_err = 0;
        exp_rfwe = 0; exp_zero = 0; lit_bus_on = 0;
        exp_addr = 0; exp_be = 0; exp_wdata = 0; exp_rfwdata = 0;
    endtask

    task automatic ghost();
        lsu_req   = ($urandom_range(0, 3) == 0);
        lsu_we    = 1'($urandom);
        lsu_type  = 2'($urandom_range(0, 2));
        lsu_sext  = 1'($urandom);
        lsu_addr  = $urandom;
        lsu_wdata = $urandom;
    endtask

    task automatic noise();
        bus.data_rvalid_i = 1'b0;
        bus.data_err_i    = 1'($urandom);
        bus.data_rdata_i  = $urandom;
    endtask

    task automatic req_phase(input logic [31:0] a, input logic [3:0] be, input logic we,
                             input logic [31:0] wd, input int gd, input logic lon,
                             input logic [31:0] la, input logic [3:0] lb, input logic [31:0] lw);
        for (int k = 0; k <= gd; k++) begin
            idle_exp();
            exp_busy = 1; exp_req = 1; exp_addr = a; exp_be = be; exp_we = we; exp_wdata = wd;
            lit_bus_on = lon; lit_addr = la; lit_be = lb; lit_wd = lw;
            ghost(); noise();
            bus.data_gnt_i = (k == gd);
            step();
        end
    endtask

    task automatic wait_cycles(input int rv);
        for (int k = 0; k < rv; k++) begin
            idle_exp(); exp_busy = 1;
            ghost(); noise();
            bus.data_gnt_i = 1'($urandom);
            step();
        end
    endtask

    task automatic resp_cycle(input logic [31:0] rd, input logic e, input logic fin,
                              input logic we, input logic [31:0] res);
        idle_exp(); exp_busy = 1;
        ghost();
        bus.data_gnt_i    = 1'($urandom);
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i  = rd;
        bus.data_err_i    = e;
        if (fin) begin
            exp_valid = 1; exp_err = e; exp_rfwe = !we && !e; exp_rfwdata = res;
        end
        step();
    endtask

    task automatic do_access(input logic we, input logic [1:0] ty, input logic sx,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int gd, input int rv,
                             input logic [31:0] rda, input logic [31:0] rdb,
                             input logic ea, input logic eb, input logic lon,
                             input logic [31:0] laa, input logic [31:0] lab,
                             input logic [3:0] lba, input logic [3:0] lbb,
                             input logic [31:0] lwd, input logic [31:0] lres);
        logic [7:0]  m;
        logic        sp;
        logic [31:0] ba, pw, res;
        m   = touched(ty, addr[1:0]);
        sp  = |m[7:4];
        ba  = {addr[31:2], 2'b00};
        pw  = place(wd, addr[1:0]);
        res = load_val({rdb, rda}, ty, sx, addr[1:0]);
        idle_exp();
        lit_res_on = lon; lit_res = lres;
        lsu_req = 1; lsu_we = we; lsu_type = ty; lsu_sext = sx;
        lsu_addr = addr; lsu_wdata = wd;
        noise();
        bus.data_gnt_i = 1'($urandom);
        step();
        if (sp && !MIS_EN) begin
            idle_exp(); exp_busy = 1; exp_valid = 1; exp_err = 1;
            ghost(); noise();
            bus.data_gnt_i = 1'($urandom);
            step();
        end else begin
            req_phase(ba, m[3:0], we, pw, gd, lon, laa, lba, lwd);
            wait_cycles(rv);
            resp_cycle(rda, ea, !(sp && !ea), we, res);
            if (sp && !ea) begin
                req_phase(ba + 32'd4, m[7:4], we, pw, gd, lon, lab, lbb, lwd);
                wait_cycles(rv);
                resp_cycle(rdb, eb, 1'b1, we, res);
            end
        end
        idle_exp();
        lit_res_on = 0;
        lsu_req = 0;
    endtask

    task automatic gap();
        idle_exp();
        lsu_req = 0;
        noise();
        bus.data_rvalid_i = 1'($urandom);
        bus.data_gnt_i    = 1'($urandom);
        step();
    endtask

    task automatic reset_mid();
        idle_exp();
        lsu_req = 1; lsu_we = 0; lsu_type = 2'b00; lsu_sext = 0;
        lsu_addr = 32'h300; lsu_wdata = 32'h0;
        noise(); bus.data_gnt_i = 0;
        step();
        req_phase(32'h300, 4'hF, 1'b0, 32'h0, 3, 1'b1, 32'h300, 4'hF, 32'h0);
        idle_exp(); exp_busy = 1;
        ghost(); noise(); bus.data_gnt_i = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        for (int k = 0; k < 2; k++) begin
            idle_exp(); exp_zero = 1;
            lsu_req = 0; noise();
            bus.data_rvalid_i = 1'b1;
            bus.data_gnt_i = 0;
            step();
        end
        idle_exp();
    endtask

    initial begin
        rst_n = 0;
        lsu_req = 0; lsu_we = 0; lsu_type = 0; lsu_sext = 0;
        lsu_addr = 0; lsu_wdata = 0;
        bus.data_gnt_i = 0; bus.data_rvalid_i = 0;
        bus.data_err_i = 0; bus.data_rdata_i = 0;
        idle_exp();
        lit_res_on = 0; lit_addr = 0; lit_be = 0; lit_wd = 0; lit_res = 0;
        step();
        exp_zero = 1; exp_chk = 1;
        step();
        rst_n = 1;
        step();
        idle_exp();

        do_access(0, 2'b00, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0,
                  1, 32'h100, 32'h104, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF);
        do_access(0, 2'b10, 1, 32'h203, 32'h0, 0, 0, 32'h80112233, 32'h0, 0, 0,
                  1, 32'h200, 32'h204, 4'b1000, 4'h0, 32'h0, 32'hFFFFFF80);
        do_access(0, 2'b10, 0, 32'h203, 32'h0, 0, 0, 32'h80112233, 32'h0, 0, 0,
                  1, 32'h200, 32'h204, 4'b1000, 4'h0, 32'h0, 32'h00000080);
        do_access(0, 2'b00, 0, 32'h102, 32'h0, 0, 0, 32'hAABBCCDD, 32'h11223344, 0, 0,
                  1, 32'h100, 32'h104, 4'b1100, 4'b0011, 32'h0, 32'h3344AABB);
        do_access(1, 2'b01, 0, 32'h003, 32'h0000BEEF, 0, 0, 32'h0, 32'h0, 0, 0,
                  1, 32'h0, 32'h4, 4'b1000, 4'b0001, 32'hEF0000BE, 32'h0);
        do_access(0, 2'b00, 0, 32'h102, 32'h0, 0, 0, 32'h12345678, 32'h9ABCDEF0, 1, 0,
                  0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
        do_access(0, 2'b00, 1, 32'hFFFFFFFE, 32'h0, 1, 1, 32'h5566_7788, 32'h1122_3344, 0, 0,
                  1, 32'hFFFFFFFC, 32'h0, 4'b1100, 4'b0011, 32'h0, 32'h33445566);
        gap();
        reset_mid();

        for (int n = 0; n < 300; n++) begin
            int g;
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) gap();
            do_access(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
                      ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15)),
                      $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom, $urandom,
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                      0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
        end
        gap();
        exp_chk = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/brq_lsu_resp.md
# brq_lsu_resp

Load/store bus sequencer and response generator for the brq core. It accepts one load or store from ID/EX and drives the data-memory request/grant/rvalid bus. Misaligned accesses are split into two word transactions. It aligns and sign- or zero-extends the load data and produces the `rf_wdata_lsu`, `rf_we_lsu`, `lsu_resp_valid` and `lsu_resp_err` signals consumed by the writeback stage.

## Interface
Parameters: none.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset; synchronous, active-low.
- `lsu_req_i` in 1: new access from ID/EX; sampled only when `busy_o`=0.
- `lsu_we_i` in 1: 1 = store, 0 = load.
- `lsu_type_i` in 2: `lsu_type_e`; word=00, half=01, byte=10.
- `lsu_sign_ext_i` in 1: sign-extend load data.
- `lsu_addr_i` in 32: byte address.
- `lsu_wdata_i` in 32: store data, LSB-aligned.
- `busy_o` out 1: an access is in flight.
- `data_req_o` out 1: bus request.
- `data_gnt_i` in 1: bus grant.
- `data_addr_o` out 32: word-aligned bus address.
- `data_we_o` out 1: bus write enable.
- `data_be_o` out 4: byte enables.
- `data_wdata_o` out 32: rotated store data.
- `data_rvalid_i` in 1: bus response.
- `data_err_i` in 1: bus error, qualified by `data_rvalid_i`.
- `data_rdata_i` in 32: bus read data.
- `rf_wdata_lsu_o` out 32: extended load result.
- `rf_we_lsu_o` out 1: register-file write for load data.
- `lsu_resp_valid_o` out 1: access complete.
- `lsu_resp_err_o` out 1: access completed with error.

## Operation
- FSM states `LSU_IDLE`, `LSU_REQ_A`, `LSU_WAIT_A`, `LSU_REQ_B`, `LSU_WAIT_B`. State is held in `lsu_state_e`.
- In IDLE, `lsu_req_i`=1 latches `we`, `type`, `sign_ext`, `addr` and `wdata`, computes `split`, and moves to REQ_A.
- `split` is 1 when type is word and `addr[1:0]`≠0, or when type is half and `addr[1:0]`=3.
- REQ_A: `data_req_o`=1, `data_addr_o`={addr[31:2],2'b00}. The address, `data_we_o`, `data_be_o` and `data_wdata_o` stay stable until `data_gnt_i`. On grant, go to WAIT_A.
- WAIT_A, on `data_rvalid_i`:
  - If `split`=1 and `data_err_i`=0: store `data_rdata_i` in `rdata_a_q` and go to REQ_B.
  - Otherwise: complete and go to IDLE.
  - An error on part A skips part B.
- REQ_B: address is the REQ_A address + 4 (wraps modulo 2^32). On grant, go to WAIT_B.
- WAIT_B: `data_rvalid_i` completes the access; go to IDLE.
- Byte enables, with o = addr[1:0]:
  - Part A: word 4'b1111<<o; half 4'b0011<<o (truncated to 4 bits); byte 4'b0001<<o.
  - Part B: word 4'b1111>>(4−o); half at o=3 gives 4'b0001.
- `data_wdata_o`: `lsu_wdata_i` rotated left by 8·o bits, identical for both parts.
- Load assembly:
  - Source is `{rdata_b, rdata_a}` for split accesses, `{32'b0, rdata}` otherwise.
  - Shift right by 8·o and take the low 32 bits.
  - Extract byte, half or word and extend per `sign_ext`.
- Completion cycle drives these combinationally:
  - `lsu_resp_valid_o`=1.
  - `lsu_resp_err_o`=`data_err_i`.
  - `rf_we_lsu_o`=~we & ~`data_err_i`.
  - `rf_wdata_lsu_o` valid.
- In all other cycles `lsu_resp_valid_o`, `lsu_resp_err_o` and `rf_we_lsu_o` are 0.
- `data_rvalid_i` is ignored in IDLE, REQ_A and REQ_B. Assertion: rvalid never arrives in REQ_x.
- `lsu_req_i` while `busy_o`=1 is ignored.

## Timing
- Reset values, all outputs: `busy_o`=0, `data_req_o`=0, `data_addr_o`=0, `data_we_o`=0, `data_be_o`=0, `data_wdata_o`=0, `rf_wdata_lsu_o`=0, `rf_we_lsu_o`=0, `lsu_resp_valid_o`=0, `lsu_resp_err_o`=0.
- `busy_o`=1 whenever state≠IDLE.
- Aligned access, grant in the first REQ cycle, rvalid one cycle later: `lsu_resp_valid_o` rises 2 cycles after `lsu_req_i`.
- Split access under the same conditions: 4 cycles.
- A new request is accepted in the cycle after completion at the earliest, because completion returns the FSM to IDLE.
- Reset mid-operation returns to IDLE next edge. A late `data_rvalid_i` is then ignored.

## Configuration
`BRQ_LSU_MISALIGNED_EN`:
- Defined: split accesses are performed as described above.
- Undefined:
  - A request with `split`=1 issues no bus transaction.
  - The FSM goes to IDLE and, one cycle after `lsu_req_i`, asserts `lsu_resp_valid_o`=1 and `lsu_resp_err_o`=1 for one cycle, with `rf_we_lsu_o`=0.
  - `busy_o`=1 during that cycle.
  - REQ_B, WAIT_B and `rdata_a_q` are not generated.

## Structure
- `brq_pkg` holds:
  - `lsu_type_e` (LSU_WORD=2'b00, LSU_HALF=2'b01, LSU_BYTE=2'b10).
  - `lsu_state_e`.
- One combinational sub-module, `brq_lsu_rdata_align`: takes the 64-bit source, offset, type and `sign_ext`, and returns the 32-bit result.

## Test plan
- Aligned LW at 0x100, gnt immediate, rdata 0xDEADBEEF: resp_valid 2 cycles after req, `rf_wdata_lsu_o`=0xDEADBEEF, `rf_we_lsu_o`=1.
- LB sign-extended at 0x203, rdata 0x80112233: `data_be_o`=4'b1000, `rf_wdata_lsu_o`=0xFFFFFF80. Same access as LBU gives 0x00000080.
- Misaligned LW at 0x102, rdata_A 0xAABBCCDD, rdata_B 0x11223344:
  - Addresses 0x100 then 0x104.
  - BE 4'b1100 then 4'b0011.
  - Result 0x3344AABB.
  - Without the macro: one-cycle error response and no `data_req_o`.
- SH at 0x003 with wdata 0x0000BEEF: `data_wdata_o`=0xEF0000BE, BE 4'b1000 then 4'b0001, `rf_we_lsu_o`=0 on completion.
- Misaligned LW with `data_err_i`=1 on part A: completes with `lsu_resp_err_o`=1, no REQ_B, `rf_we_lsu_o`=0.
- Grant delayed 3 cycles, plus `rst_ni`=0 asserted in WAIT_A: address stable through the stall; after reset all outputs are 0 and a subsequent rvalid produces no response.
